result_drain: RTL and testbench
===============================

# result_drain

Downstream stage of the systolic array: captures the full `A_ROWS x B_COLS` result matrix in one cycle when the array reports completion, then streams the elements out one per accepted beat in row-major order over a valid/ready handshake. The block flattens the matrix for memory writes and owns the only snapshot of the result. This frees the array to start the next multiplication while the previous product is still draining.

## Interface
Parameters:
- `DATA_WIDTH`, 8, operand width; result elements are `2*DATA_WIDTH` bits
- `A_ROWS`, 2, rows of C
- `B_COLS`, 2, columns of C

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (assert low clears all state immediately)
- `result`  in  `[2*DATA_WIDTH-1:0]` unpacked `[0:A_ROWS-1][0:B_COLS-1]`  result matrix from the array
- `capture`  in  1  one-cycle pulse: `result` is valid this cycle
- `out_data`  out  `2*DATA_WIDTH`  current element
- `out_addr`  out  `$clog2(A_ROWS*B_COLS)` (min 1)  row-major index `i*B_COLS+j`
- `out_valid`  out  1  `out_data`/`out_addr`/`out_last` valid
- `out_ready`  in  1  sink accepts the beat when high together with `out_valid`
- `out_last`  out  1  high on the final element (index `A_ROWS*B_COLS-1`)
- `busy`  out  1  high while a matrix is held or draining
- `overrun`  out  1  sticky: a `capture` arrived while busy

## Operation
- States: `IDLE`, `DRAIN`.
- `IDLE`: `capture`=1 -> copy every `result[i][j]` into snapshot register, clear row/col counters, go `DRAIN`.
- `DRAIN`: `out_valid`=1; `out_data`=snapshot[row][col]; `out_addr`=row*B_COLS+col; `out_last`=1 when row=A_ROWS-1 and col=B_COLS-1.
- Beat accepted (`out_valid && out_ready`): col increments; col wraps to 0 at `B_COLS-1` and row increments. On acceptance of the last beat -> `IDLE`.
- `out_ready` low: all outputs held stable; no counter change.
- `capture` while in `DRAIN`, including the cycle of last-beat acceptance: ignored, snapshot unchanged, `overrun` set. `overrun` clears only on reset.
- No combinational path from `out_ready` to `out_valid`/`out_data`.
- Width: elements stored at full `2*DATA_WIDTH`, never truncated.
- Degenerate `A_ROWS*B_COLS`=1: the single beat has `out_last`=1.

## Timing
- Reset (low, any time including mid-drain): state `IDLE`, counters 0, snapshot 0, `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0, `busy`=0, `overrun`=0. A drain in progress is abandoned.
- Latency: `capture` in cycle N -> first beat `out_valid`=1 in cycle N+1.
- Throughput: one element per cycle with `out_ready` held high; full matrix drains in `A_ROWS*B_COLS` cycles.
- `busy`=1 from cycle N+1 through the cycle of last-beat acceptance; `busy`=0 the following cycle. A new `capture` is accepted in that following cycle.
- `busy` is registered and equals (state==`DRAIN`).

## Structure
- Shared package `matmul_pkg`: `drain_state_t` enum (`IDLE`, `DRAIN`) and the address-width function (`clog2` with a minimum of 1), reused by neighbouring stages.
- No sub-module. The row/col counters and snapshot stay inline; one always_ff block with async reset and a separate combinational output assignment.

## Test plan
- Setup for all cases: 2x2, `DATA_WIDTH`=8.
- Reset then idle: all outputs 0 and `busy`=0 for 10 cycles with `capture`=0.
- 2x2 basic drain: `result`={{0x0001,0x0002},{0x0003,0x0004}}, capture, `out_ready`=1 -> beats (addr,data)=(0,1),(1,2),(2,3),(3,4) in consecutive cycles starting 1 cycle after capture; `out_last` on addr 3; `busy` falls the cycle after.
- Backpressure: same matrix with `out_ready` toggling 1,0,0,1,... -> data and address held stable while ready=0; same 4 beats in order; no drops or duplicates.
- Overrun: capture 0xAAAA matrix, then capture 0x5555 during beat 1 -> drain still emits 0xAAAA x4, `overrun`=1 and stays 1; capture after `busy`=0 drains 0x5555 and `overrun` stays 1.
- Reset mid-drain: assert reset low after beat 1 -> outputs 0 immediately (asynchronous); after release, a new capture drains from addr 0.
- Full-width values and 3x2 config: element 0xFFFF passes untruncated; 3x2 emits addresses 0..5 with `out_last` only at 5.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul pipeline stages.
package matmul_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    // Index width with a floor of one bit so degenerate 1-element shapes still get a port.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/result_drain.sv
// Snapshots the systolic array's result matrix on capture and streams it out
// row-major, one element per accepted valid/ready beat.
module result_drain
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int A_ROWS     = 2,
    parameter int B_COLS     = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [2*DATA_WIDTH-1:0]                result [0:A_ROWS-1][0:B_COLS-1],
    input  logic                                   capture,
    output logic [2*DATA_WIDTH-1:0]                out_data,
    output logic [clog2_min1(A_ROWS*B_COLS)-1:0]   out_addr,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_last,
    output logic                                   busy,
    output logic                                   overrun
);

    localparam int EW = 2 * DATA_WIDTH;
    localparam int AW = clog2_min1(A_ROWS * B_COLS);
    localparam int RW = clog2_min1(A_ROWS);
    localparam int CW = clog2_min1(B_COLS);

    drain_state_t  state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          overrun_q, overrun_d;
    logic [EW-1:0] snap_q [0:A_ROWS-1][0:B_COLS-1];
    logic [EW-1:0] snap_d [0:A_ROWS-1][0:B_COLS-1];

    logic draining;
    logic at_last;

    assign draining = (state_q == DRAIN);
    assign at_last  = (row_q == RW'(A_ROWS - 1)) && (col_q == CW'(B_COLS - 1));

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        overrun_d = overrun_q;
        snap_d    = snap_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    snap_d  = result;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The snapshot is the only copy; a second capture must not clobber it.
                if (capture) begin
                    overrun_d = 1'b1;
                end
                if (out_ready) begin
                    if (at_last) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = IDLE;
                    end else if (col_q == CW'(B_COLS - 1)) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < A_ROWS; i++) begin
                for (int j = 0; j < B_COLS; j++) begin
                    snap_q[i][j] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            overrun_q <= overrun_d;
            snap_q    <= snap_d;
        end
    end

    // Outputs depend only on registered state, so out_ready never reaches out_valid/out_data.
    assign out_valid = draining;
    assign busy      = draining;
    assign overrun   = overrun_q;
    assign out_last  = draining && at_last;
    assign out_data  = draining ? snap_q[row_q][col_q] : '0;
    assign out_addr  = draining ? AW'(int'(row_q) * B_COLS + int'(col_q)) : '0;

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: a 2x2 and a 3x2 instance checked against a queue-based beat model.
module tb_result_drain;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } beat_t;

    logic        clk;
    logic        reset_n;

    logic [15:0] res2 [0:1][0:1];
    logic        cap2, rdy2;
    logic [15:0] data2;
    logic [1:0]  addr2;
    logic        valid2, last2, busy2, over2;

    logic [15:0] res3 [0:2][0:1];
    logic        cap3, rdy3;
    logic [15:0] data3;
    logic [2:0]  addr3;
    logic        valid3, last3, busy3, over3;

    beat_t q2[$];
    beat_t q3[$];
    bit    ov2, ov3;
    int    checks, errors;

    result_drain #(.DATA_WIDTH(8), .A_ROWS(2), .B_COLS(2)) dut2 (
        .clk(clk), .reset(reset_n), .result(res2), .capture(cap2),
        .out_data(data2), .out_addr(addr2), .out_valid(valid2), .out_ready(rdy2),
        .out_last(last2), .busy(busy2), .overrun(over2)
    );

    result_drain #(.DATA_WIDTH(8), .A_ROWS(3), .B_COLS(2)) dut3 (
        .clk(clk), .reset(reset_n), .result(res3), .capture(cap3),
        .out_data(data3), .out_addr(addr3), .out_valid(valid3), .out_ready(rdy3),
        .out_last(last3), .busy(busy3), .overrun(over3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero();
        chk("rst_valid2", {31'd0, valid2}, 0);
        chk("rst_data2",  {16'd0, data2},  0);
        chk("rst_addr2",  {30'd0, addr2},  0);
        chk("rst_last2",  {31'd0, last2},  0);
        chk("rst_busy2",  {31'd0, busy2},  0);
        chk("rst_over2",  {31'd0, over2},  0);
        chk("rst_valid3", {31'd0, valid3}, 0);
        chk("rst_data3",  {16'd0, data3},  0);
        chk("rst_addr3",  {29'd0, addr3},  0);
        chk("rst_busy3",  {31'd0, busy3},  0);
    endtask

    task automatic compare();
        chk("valid2",   {31'd0, valid2}, (q2.size() > 0) ? 1 : 0);
        chk("busy2",    {31'd0, busy2},  (q2.size() > 0) ? 1 : 0);
        chk("overrun2", {31'd0, over2},  {31'd0, ov2});
        if (q2.size() > 0) begin
            chk("addr2", {30'd0, addr2}, q2[0].addr);
            chk("data2", {16'd0, data2}, {16'd0, q2[0].data});
            chk("last2", {31'd0, last2}, (q2[0].addr == 3) ? 1 : 0);
        end
        chk("valid3",   {31'd0, valid3}, (q3.size() > 0) ? 1 : 0);
        chk("busy3",    {31'd0, busy3},  (q3.size() > 0) ? 1 : 0);
        chk("overrun3", {31'd0, over3},  {31'd0, ov3});
        if (q3.size() > 0) begin
            chk("addr3", {29'd0, addr3}, q3[0].addr);
            chk("data3", {16'd0, data3}, {16'd0, q3[0].data});
            chk("last3", {31'd0, last3}, (q3[0].addr == 5) ? 1 : 0);
        end
    endtask

    // One clock: model consumes what the DUT sampled at this edge, then outputs are compared.
    task automatic tick();
        bit b2, b3;
        b2 = (q2.size() > 0);
        b3 = (q3.size() > 0);
        @(posedge clk);
        if (reset_n) begin
            if (cap2 && b2) ov2 = 1'b1;
            else if (cap2) begin
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++)
                        q2.push_back('{addr: i * 2 + j, data: res2[i][j]});
            end
            if (b2 && rdy2) void'(q2.pop_front());
            if (cap3 && b3) ov3 = 1'b1;
            else if (cap3) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 2; j++)
                        q3.push_back('{addr: i * 2 + j, data: res3[i][j]});
            end
            if (b3 && rdy3) void'(q3.pop_front());
        end
        #1;
        compare();
    endtask

    task automatic start2();
        cap2 = 1'b1;
        tick();
        cap2 = 1'b0;
    endtask

    // mode 0: ready high, 1: ready pattern 1,0,0,..., 2: random ready.
    // cap_rem: raise capture while this many beats remain (-1 never).
    task automatic drain2(input int mode, input int cap_rem);
        int k;
        k = 0;
        while (q2.size() > 0 && k < 200) begin
            case (mode)
                0:       rdy2 = 1'b1;
                1:       rdy2 = ((k % 3) == 0);
                default: rdy2 = 1'($urandom_range(0, 1));
            endcase
            cap2 = (q2.size() == cap_rem);
            tick();
            k++;
        end
        cap2 = 1'b0;
    endtask

    task automatic set2(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
        res2[0][0] = a; res2[0][1] = b; res2[1][0] = c; res2[1][1] = d;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        ov2     = 0;
        ov3     = 0;
        reset_n = 1'b0;
        cap2    = 1'b0;
        rdy2    = 1'b0;
        cap3    = 1'b0;
        rdy3    = 1'b1;
        set2(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            res3[i][0] = '0;
            res3[i][1] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_zero();
        reset_n = 1'b1;

        repeat (10) begin
            tick();
            check_zero();
        end

        // basic drain
        set2(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        rdy2 = 1'b1;
        start2();
        drain2(0, -1);
        tick();

        // backpressure
        start2();
        drain2(1, -1);
        tick();

        // capture coinciding with last-beat acceptance is ignored
        set2(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        start2();
        set2(16'h9999, 16'h8888, 16'h7777, 16'h6666);
        drain2(0, 1);
        start2();
        drain2(0, -1);

        // reset in the middle of a drain
        set2(16'hBEEF, 16'hCAFE, 16'hF00D, 16'h1234);
        start2();
        rdy2 = 1'b1;
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        check_zero();
        q2.delete();
        q3.delete();
        ov2 = 0;
        ov3 = 0;
        tick();
        reset_n = 1'b1;
        tick();
        start2();
        drain2(0, -1);

        // overrun: second capture during the drain keeps the first matrix
        set2(16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA);
        start2();
        set2(16'h5555, 16'h5555, 16'h5555, 16'h5555);
        rdy2 = 1'b1;
        cap2 = 1'b1;
        tick();
        cap2 = 1'b0;
        drain2(0, -1);
        start2();
        drain2(2, -1);
        tick();

        // random matrices with full-width corner values
        repeat (4) begin
            set2(16'($urandom), 16'($urandom), 16'($urandom), 16'hFFFF);
            repeat ($urandom_range(0, 2)) tick();
            start2();
            drain2(2, -1);
        end

        // 3x2 instance
        repeat (3) begin
            for (int i = 0; i < 3; i++) begin
                res3[i][0] = 16'($urandom);
                res3[i][1] = 16'($urandom);
            end
            res3[0][0] = 16'hFFFF;
            cap3 = 1'b1;
            tick();
            cap3 = 1'b0;
            for (int k = 0; k < 200 && q3.size() > 0; k++) begin
                rdy3 = 1'($urandom_range(0, 1));
                tick();
            end
            rdy3 = 1'b1;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
